// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg: shared types and sizing helpers for the LFSR sequencer.
//   lfsr_ctrl_state_t : sequencer state encoding
//   step_cnt_width()  : width of the down-counter that holds STEPS-1
//   idx_width()       : width of a requester index for n requesters

package lfsr_ctrl_pkg;

   typedef enum logic [2:0] {
      StUnseeded = 3'd0,
      StIdle     = 3'd1,
      StLoad     = 3'd2,
      StStep     = 3'd3,
      StDeliver  = 3'd4
   } lfsr_ctrl_state_t;

   // The counter only has to hold STEPS-1, so STEPS itself needs no extra bit.
   function automatic int unsigned step_cnt_width(input int unsigned steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lfsr32.sv
// lfsr32: N-bit Fibonacci LFSR, no reset.
//   clk_i  : clock
//   init_i : synchronous load of seed_i (wins over go_i)
//   go_i   : advance one step
//   seed_i : load value
//   q_o    : current state
// Shifts toward bit 0; the feedback bit enters at the MSB.
// Default taps give x^32 + x^22 + x^2 + x + 1.

module lfsr32 #(
   parameter int unsigned     N    = 32,
   parameter logic [N-1:0]    Taps = 32'h8020_0003
) (
   input  logic         clk_i,
   input  logic         init_i,
   input  logic         go_i,
   input  logic [N-1:0] seed_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] q_q;
   logic [N-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (init_i) begin
         q_d = seed_i;
      end else if (go_i) begin
         q_d = {^(q_q & Taps), q_q[N-1:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i   : request vector
//   ptr_i   : highest-priority index (must be < NREQ)
//   gnt_o   : one-hot winner, zero when no request
//   idx_o   : winner index
//   valid_o : any request present
// Winner is the first set bit at or after ptr_i, wrapping NREQ-1 -> 0.

module rr_arbiter import lfsr_ctrl_pkg::*; #(
   parameter int unsigned  NREQ = 4,
   localparam int unsigned IdxW = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o
);

   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic [IdxW-1:0]   off;
   logic [IdxW:0]     sum;

   // Rotate so that ptr_i lands at bit 0; a plain priority pick then gives
   // the offset of the winner from the pointer.
   assign req_dbl = {req_i, req_i} >> ptr_i;
   assign req_rot = req_dbl[NREQ-1:0];

   always_comb begin
      off     = '0;
      valid_o = 1'b0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            off     = IdxW'(i);
            valid_o = 1'b1;
         end
      end
   end

   assign sum   = {1'b0, ptr_i} + {1'b0, off};
   assign idx_o = (sum >= (IdxW+1)'(NREQ)) ? IdxW'(sum - (IdxW+1)'(NREQ)) : sum[IdxW-1:0];
   assign gnt_o = valid_o ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: seed handshake, step sequencer and round-robin arbiter in front
// of a single lfsr32.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   seed_valid_i/seed_i: seed load request, held until ack or err
//   seed_ack_o         : seed accepted (pulse, during the load cycle)
//   seed_err_o         : all-zero seed rejected (pulse)
//   seeded_o           : a seed has been accepted since reset
//   req_i / gnt_o      : per-requester word request / one-hot grant pulse
//   rvalid_o, rdata_o  : delivered word, zero when not valid
//   lfsr_init_o, lfsr_go_o, lfsr_seed_o : drive lfsr32
//   lfsr_q_i           : lfsr32 state

module lfsr_ctrl import lfsr_ctrl_pkg::*; #(
   parameter int unsigned N     = 32,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned STEPS = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            seed_valid_i,
   input  logic [N-1:0]    seed_i,
   output logic            seed_ack_o,
   output logic            seed_err_o,
   output logic            seeded_o,
   input  logic [NREQ-1:0] req_i,
   output logic [NREQ-1:0] gnt_o,
   output logic            rvalid_o,
   output logic [N-1:0]    rdata_o,
   output logic            lfsr_init_o,
   output logic            lfsr_go_o,
   output logic [N-1:0]    lfsr_seed_o,
   input  logic [N-1:0]    lfsr_q_i
);

   localparam int unsigned IdxW = idx_width(NREQ);
   localparam int unsigned CntW = step_cnt_width(STEPS);

   lfsr_ctrl_state_t state_q, state_d;
   logic [IdxW-1:0]  ptr_q, ptr_d;
   logic [IdxW-1:0]  win_idx_q, win_idx_d;
   logic [NREQ-1:0]  win_oh_q, win_oh_d;
   logic [N-1:0]     seed_q, seed_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             seeded_q, seeded_d;
   logic             err_q, err_d;

   logic [NREQ-1:0]  arb_gnt;
   logic [IdxW-1:0]  arb_idx;
   logic             arb_valid;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_idx_d = win_idx_q;
      win_oh_d  = win_oh_q;
      seed_d    = seed_q;
      cnt_d     = cnt_q;
      seeded_d  = seeded_q;
      err_d     = 1'b0;

      unique case (state_q)
         StUnseeded, StIdle: begin
            // Seed loads take priority over word requests; requests are only
            // served once the LFSR holds a known, non-zero state.
            if (seed_valid_i) begin
               if (seed_i == '0) begin
                  err_d = 1'b1;
               end else begin
                  seed_d  = seed_i;
                  state_d = StLoad;
               end
            end else if ((state_q == StIdle) && arb_valid) begin
               win_idx_d = arb_idx;
               win_oh_d  = arb_gnt;
               cnt_d     = CntW'(STEPS - 1);
               state_d   = StStep;
            end
         end
         StLoad: begin
            seeded_d = 1'b1;
            state_d  = StIdle;
         end
         StStep: begin
            if (cnt_q == '0) begin
               state_d = StDeliver;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StDeliver: begin
            ptr_d   = (win_idx_q == IdxW'(NREQ - 1)) ? '0 : win_idx_q + IdxW'(1);
            state_d = StIdle;
         end
         default: begin
            state_d = StUnseeded;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StUnseeded;
         ptr_q     <= '0;
         win_idx_q <= '0;
         win_oh_q  <= '0;
         seed_q    <= '0;
         cnt_q     <= '0;
         seeded_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_idx_q <= win_idx_d;
         win_oh_q  <= win_oh_d;
         seed_q    <= seed_d;
         cnt_q     <= cnt_d;
         seeded_q  <= seeded_d;
         err_q     <= err_d;
      end
   end

   // Outputs decode straight from registered state, so an asynchronous reset
   // clears all of them without waiting for a clock.
   assign seed_ack_o  = (state_q == StLoad);
   assign lfsr_init_o = (state_q == StLoad);
   assign lfsr_go_o   = (state_q == StStep);
   assign rvalid_o    = (state_q == StDeliver);
   assign gnt_o       = rvalid_o ? win_oh_q : '0;
   assign rdata_o     = rvalid_o ? lfsr_q_i : '0;
   assign lfsr_seed_o = seed_q;
   assign seeded_o    = seeded_q;
   assign seed_err_o  = err_q;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Bench for lfsr_ctrl + lfsr32. Instance 0 runs STEPS=1, instance 1 STEPS=8.
module tb_lfsr_ctrl;

   localparam int unsigned N    = 32;
   localparam int unsigned NREQ = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic            sv     [2];
   logic [N-1:0]    seed   [2];
   logic [NREQ-1:0] req    [2];
   logic            ack    [2];
   logic            err    [2];
   logic            seeded [2];
   logic [NREQ-1:0] gnt    [2];
   logic            rvalid [2];
   logic [N-1:0]    rdata  [2];
   logic            init   [2];
   logic            go     [2];
   logic [N-1:0]    lseed  [2];
   logic [N-1:0]    lq     [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      lfsr_ctrl #(
         .N     (N),
         .NREQ  (NREQ),
         .STEPS ((g == 0) ? 32'd1 : 32'd8)
      ) u_ctrl (
         .clk_i        (clk),
         .rst_ni       (rst_n),
         .seed_valid_i (sv[g]),
         .seed_i       (seed[g]),
         .seed_ack_o   (ack[g]),
         .seed_err_o   (err[g]),
         .seeded_o     (seeded[g]),
         .req_i        (req[g]),
         .gnt_o        (gnt[g]),
         .rvalid_o     (rvalid[g]),
         .rdata_o      (rdata[g]),
         .lfsr_init_o  (init[g]),
         .lfsr_go_o    (go[g]),
         .lfsr_seed_o  (lseed[g]),
         .lfsr_q_i     (lq[g])
      );
      lfsr32 #(
         .N (N)
      ) u_lfsr (
         .clk_i  (clk),
         .init_i (init[g]),
         .go_i   (go[g]),
         .seed_i (lseed[g]),
         .q_o    (lq[g])
      );
   end

   typedef struct packed {
      logic            ack;
      logic            err;
      logic            seeded;
      logic [NREQ-1:0] gnt;
      logic            rvalid;
      logic [N-1:0]    rdata;
      logic            init;
      logic            go;
      logic [N-1:0]    lseed;
   } obs_t;

   typedef struct packed {
      logic            sv;
      logic [N-1:0]    seed;
      logic [NREQ-1:0] req;
      obs_t            exp;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   // x^32 + x^22 + x^2 + x + 1, shifting toward bit 0.
   function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return {fb, s[N-1:1]};
   endfunction

   function automatic obs_t observe(input int d);
      obs_t o;
      o.ack = ack[d]; o.err = err[d]; o.seeded = seeded[d]; o.gnt = gnt[d];
      o.rvalid = rvalid[d]; o.rdata = rdata[d]; o.init = init[d]; o.go = go[d];
      o.lseed = lseed[d];
      return o;
   endfunction

   function automatic obs_t ob(input logic a, input logic e, input logic sd,
                               input logic [NREQ-1:0] g, input logic rv,
                               input logic [N-1:0] rd, input logic in, input logic gg,
                               input logic [N-1:0] ls);
      obs_t o;
      o.ack = a; o.err = e; o.seeded = sd; o.gnt = g; o.rvalid = rv; o.rdata = rd;
      o.init = in; o.go = gg; o.lseed = ls;
      return o;
   endfunction

   function automatic vec_t mk(input logic s, input logic [N-1:0] sd,
                               input logic [NREQ-1:0] r, input obs_t e);
      vec_t v;
      v.sv = s; v.seed = sd; v.req = r; v.exp = e;
      return v;
   endfunction

   task automatic compare(input string name, input obs_t a, input obs_t e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s t=%0t: got ack=%b err=%b seeded=%b gnt=%b rvalid=%b rdata=%h init=%b go=%b lseed=%h; required ack=%b err=%b seeded=%b gnt=%b rvalid=%b rdata=%h init=%b go=%b lseed=%h",
                  name, $time, a.ack, a.err, a.seeded, a.gnt, a.rvalid, a.rdata, a.init, a.go,
                  a.lseed, e.ack, e.err, e.seeded, e.gnt, e.rvalid, e.rdata, e.init, e.go, e.lseed);
      end
   endtask

   task automatic compare_int(input string name, input int a, input int e);
      n_vec++;
      if (a != e) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, a, e);
      end
   endtask

   // Reference model: a queue of the outputs each busy cycle must show,
   // filled whenever an idle-cycle decision starts a seed load or a word.
   obs_t            m_q[$];
   int              m_ptr;
   logic            m_seeded;
   logic            m_err;
   logic [N-1:0]    m_lseed;
   logic [N-1:0]    m_lfsr;
   int              cur = 0;
   int              cyc = 0;

   logic            drv_sv;
   logic [N-1:0]    drv_seed;
   logic [NREQ-1:0] drv_req;

   int ack_cyc;
   int gcyc [NREQ];
   logic [NREQ-1:0] first_gnt;

   task automatic model_reset();
      m_q.delete();
      m_ptr = 0; m_seeded = 1'b0; m_err = 1'b0; m_lseed = '0;
   endtask

   function automatic obs_t model_expect();
      obs_t e;
      e = '0;
      if (m_q.size() != 0) e = m_q[0];
      e.seeded = m_seeded; e.lseed = m_lseed; e.err = m_err;
      return e;
   endfunction

   task automatic model_edge();
      obs_t r;
      int   steps;
      int   w;
      steps = (cur == 0) ? 1 : 8;
      m_err = 1'b0;
      if (m_q.size() != 0) begin
         r = m_q.pop_front();
         if (r.init) m_seeded = 1'b1;
      end else if (drv_sv) begin
         if (drv_seed == '0) begin
            m_err = 1'b1;
         end else begin
            m_lseed = drv_seed; m_lfsr = drv_seed;
            r = '0; r.ack = 1'b1; r.init = 1'b1;
            m_q.push_back(r);
         end
      end else if (m_seeded && drv_req != '0) begin
         w = -1;
         for (int k = 0; k < int'(NREQ); k++) begin
            if (w < 0 && drv_req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         end
         m_ptr = (w + 1) % NREQ;
         for (int s = 0; s < steps; s++) begin
            m_lfsr = lfsr_next(m_lfsr);
            r = '0; r.go = 1'b1;
            m_q.push_back(r);
         end
         r = '0; r.gnt = NREQ'(1) << w; r.rvalid = 1'b1; r.rdata = m_lfsr;
         m_q.push_back(r);
      end
   endtask

   task automatic apply_inputs();
      sv[cur] = drv_sv; seed[cur] = drv_seed; req[cur] = drv_req;
   endtask

   task automatic mark();
      ack_cyc = -1; first_gnt = '0;
      for (int b = 0; b < int'(NREQ); b++) gcyc[b] = -1;
   endtask

   task automatic tick(input string name);
      obs_t a;
      @(negedge clk);
      a = observe(cur);
      compare(name, a, model_expect());
      if (a.ack && ack_cyc < 0) ack_cyc = cyc;
      if (first_gnt == '0) first_gnt = a.gnt;
      for (int b = 0; b < int'(NREQ); b++) if (a.gnt[b] && gcyc[b] < 0) gcyc[b] = cyc;
      if (a.ack || a.err) drv_sv = 1'b0;
      drv_req = drv_req & ~a.gnt;
      apply_inputs();
      model_edge();
      cyc++;
   endtask

   task automatic run(input string name, input int n);
      for (int i = 0; i < n; i++) tick(name);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drv_sv = 1'b0; drv_seed = '0; drv_req = '0;
      for (int d = 0; d < 2; d++) begin
         sv[d] = 1'b0; seed[d] = '0; req[d] = '0;
      end
      model_reset();
      mark();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t            tbl[$];
      logic [N-1:0]    s;
      logic [N-1:0]    w [7];
      obs_t            z;
      z = '0;
      s = 32'h1234_5678;
      w[0] = s;
      for (int i = 1; i < 7; i++) w[i] = lfsr_next(w[i-1]);

      // ---- Table: STEPS=1 instance, cycle by cycle ----
      cur = 0;
      do_reset();
      for (int i = 0; i < 20; i++) tbl.push_back(mk(1'b0, '0, 4'b1111, z));
      tbl.push_back(mk(1'b1, '0, 4'b0000, z));
      tbl.push_back(mk(1'b0, '0, 4'b0000, ob(0, 1, 0, 4'b0000, 0, '0, 0, 0, '0)));
      tbl.push_back(mk(1'b1, s,  4'b0000, z));
      tbl.push_back(mk(1'b0, s,  4'b0000, ob(1, 0, 0, 4'b0000, 0, '0, 1, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b0001, ob(0, 0, 1, 4'b0000, 0, '0, 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b0001, ob(0, 0, 1, 4'b0000, 0, '0, 0, 1, s)));
      tbl.push_back(mk(1'b0, s,  4'b1111, ob(0, 0, 1, 4'b0001, 1, w[1], 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b1111, ob(0, 0, 1, 4'b0000, 0, '0, 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b1111, ob(0, 0, 1, 4'b0000, 0, '0, 0, 1, s)));
      tbl.push_back(mk(1'b0, s,  4'b1101, ob(0, 0, 1, 4'b0010, 1, w[2], 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b1101, ob(0, 0, 1, 4'b0000, 0, '0, 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b1101, ob(0, 0, 1, 4'b0000, 0, '0, 0, 1, s)));
      tbl.push_back(mk(1'b0, s,  4'b1001, ob(0, 0, 1, 4'b0100, 1, w[3], 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b1001, ob(0, 0, 1, 4'b0000, 0, '0, 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b1001, ob(0, 0, 1, 4'b0000, 0, '0, 0, 1, s)));
      tbl.push_back(mk(1'b0, s,  4'b1010, ob(0, 0, 1, 4'b1000, 1, w[4], 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b1010, ob(0, 0, 1, 4'b0000, 0, '0, 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b1010, ob(0, 0, 1, 4'b0000, 0, '0, 0, 1, s)));
      tbl.push_back(mk(1'b0, s,  4'b1000, ob(0, 0, 1, 4'b0010, 1, w[5], 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b1000, ob(0, 0, 1, 4'b0000, 0, '0, 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b1000, ob(0, 0, 1, 4'b0000, 0, '0, 0, 1, s)));
      tbl.push_back(mk(1'b0, s,  4'b0000, ob(0, 0, 1, 4'b1000, 1, w[6], 0, 0, s)));
      tbl.push_back(mk(1'b0, s,  4'b0000, ob(0, 0, 1, 4'b0000, 0, '0, 0, 0, s)));
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         compare($sformatf("table[%0d]", i), observe(0), tbl[i].exp);
         sv[0] = tbl[i].sv; seed[0] = tbl[i].seed; req[0] = tbl[i].req;
      end

      // ---- Seed arriving during STEP (STEPS=8) ----
      cur = 1;
      do_reset();
      drv_sv = 1'b1; drv_seed = 32'hCAFE_0001;
      run("seed_a", 3);
      drv_req = 4'b0001;
      run("req0", 3);
      mark();
      drv_sv = 1'b1; drv_seed = 32'h0BAD_F00D;
      drv_req = drv_req | 4'b0100;
      run("seed_in_step", 24);
      compare_int("grant0_seen", (gcyc[0] >= 0) ? 1 : 0, 1);
      compare_int("ack_two_after_grant", ack_cyc, gcyc[0] + 2);
      compare_int("grant2_after_ack", gcyc[2], ack_cyc + 10);

      // ---- Reset pulsed low during STEP ----
      drv_req = 4'b1111;
      run("pre_reset", 4);
      #2;
      rst_n = 1'b0;
      #1;
      compare("reset_mid_step", observe(1), '0);
      do_reset();
      drv_req = 4'b1111;
      run("unseeded_after_reset", 20);
      mark();
      drv_sv = 1'b1; drv_seed = 32'h0000_0001;
      run("reseed", 14);
      compare_int("first_grant_after_reset", int'(first_gnt), 1);

      // ---- Randomized traffic on both instances ----
      for (int d = 0; d < 2; d++) begin
         cur = d;
         do_reset();
         for (int c = 0; c < 700; c++) begin
            if (!drv_sv && $urandom_range(0, 24) == 0) begin
               drv_sv   = 1'b1;
               drv_seed = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            end
            for (int b = 0; b < int'(NREQ); b++) begin
               if (!drv_req[b] && $urandom_range(0, 3) == 0) drv_req[b] = 1'b1;
            end
            tick($sformatf("random_d%0d", d));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
